// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } seq_state_e;

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_FILTER_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_MAX_RETRIES         = 3;
  localparam int unsigned DEF_NUM_DOMAINS         = 5;

  // Counter width for a limit, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, qualifies lock, then releases
// downstream domain resets one per cycle, retrying a bounded number of times.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned NUM_DOMAINS         = DEF_NUM_DOMAINS,
  localparam int unsigned RCW                = cnt_width(MAX_RETRIES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   restart_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   ready,
  output logic                   fault,
  output logic [RCW-1:0]         retry_count
);

  localparam int unsigned RW = cnt_width(RST_PULSE_CYCLES);
  localparam int unsigned TW = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int unsigned FW = cnt_width(LOCK_FILTER_CYCLES);
  localparam int unsigned DW = cnt_width(NUM_DOMAINS);

  localparam logic [RW-1:0]  RST_LAST  = RW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0]  FLT_LAST  = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [DW-1:0]  REL_LAST  = DW'(NUM_DOMAINS - 1);
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRIES);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  seq_state_e             state_q, state_d;
  logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [FW-1:0]          flt_cnt_q, flt_cnt_d;
  logic [DW-1:0]          rel_cnt_q, rel_cnt_d;
  logic [RCW-1:0]         retry_q, retry_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   fail_s;

  // Next-state, counter and output computation
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    flt_cnt_d = flt_cnt_q;
    rel_cnt_d = rel_cnt_q;
    retry_d   = retry_q;
    fail_s    = 1'b0;

    case (state_q)
      RST_PLL: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          rst_cnt_d = '0;
          tmo_cnt_d = '0;
          flt_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      WAIT_LOCK: begin
        // The detecting cycle counts as the first filtered lock-high cycle
        if (lock_s) begin
          tmo_cnt_d = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
          if (LOCK_FILTER_CYCLES <= 1) begin
            state_d   = RELEASE;
            rel_cnt_d = '0;
          end else begin
            state_d   = FILTER;
            flt_cnt_d = FW'(1);
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          fail_s = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      FILTER: begin
        if (lock_s && (flt_cnt_q == FLT_LAST)) begin
          state_d   = RELEASE;
          rel_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          fail_s = 1'b1;
        end else if (!lock_s) begin
          state_d   = WAIT_LOCK;
          flt_cnt_d = '0;
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end else begin
          flt_cnt_d = flt_cnt_q + FW'(1);
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          fail_s = 1'b1;
        end else if (rel_cnt_q == REL_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + DW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RST_PLL;
      end
    endcase

    if (fail_s) begin
      rst_cnt_d = '0;
      tmo_cnt_d = '0;
      flt_cnt_d = '0;
      rel_cnt_d = '0;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RCW'(1);
        state_d = RST_PLL;
      end else begin
        state_d = FAULT;
      end
    end else begin
      retry_d = retry_d;
    end

    // Restart overrides everything, including a coincident failure
    if (restart_req) begin
      state_d   = RST_PLL;
      rst_cnt_d = '0;
      tmo_cnt_d = '0;
      flt_cnt_d = '0;
      rel_cnt_d = '0;
      retry_d   = '0;
    end else begin
      state_d = state_d;
    end

    pll_rst_d = (state_d == RST_PLL) || (state_d == FAULT);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      dom_d[i] = (state_d == RUN) || ((state_d == RELEASE) && (DW'(i) <= rel_cnt_d));
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= RST_PLL;
      rst_cnt_q <= '0;
      tmo_cnt_q <= '0;
      flt_cnt_q <= '0;
      rel_cnt_q <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      flt_cnt_q <= flt_cnt_d;
      rel_cnt_q <= rel_cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst        = pll_rst_q;
  assign domain_reset_n = dom_q;
  assign ready          = ready_q;
  assign fault          = fault_q;
  assign retry_count    = retry_q;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: cycles `pll_rst` is held high per PLL reset attempt.
REQ-002 SHALL have parameter LOCK_FILTER_CYCLES, default 1024: consecutive synchronized-lock cycles required before lock is accepted.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum cycles spent waiting for lock per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: number of re-attempts after the first attempt before declaring a fault.
REQ-005 SHALL have parameter NUM_DOMAINS, default 5: number of downstream clock-domain resets, one per PLL output clock.
REQ-006 SHALL have port `clk`, input, 1 bit: free-running reference clock, the only clock.
REQ-007 SHALL have port `reset_n`, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port `pll_locked`, input, 1 bit: raw PLL lock, asynchronous to `clk`.
REQ-009 SHALL have port `restart_req`, input, 1 bit: single-cycle request for a full re-sequence.
REQ-010 SHALL have port `pll_rst`, output, 1 bit: active-high PLL reset.
REQ-011 SHALL have port `domain_reset_n`, output, NUM_DOMAINS bits: active-low resets for the downstream domains.
REQ-012 SHALL have port `ready`, output, 1 bit: all domains are released and lock is stable.
REQ-013 SHALL have port `fault`, output, 1 bit: retries are exhausted.
REQ-014 SHALL have port `retry_count`, output, clog2(MAX_RETRIES+1) bits: number of attempts made after the first.

Function
REQ-015 SHALL pass `pll_locked` through a 2-flop synchronizer; all references to "lock" below mean the synchronized signal, which lags the raw input by 2 cycles.
REQ-016 SHALL implement the FSM states RST_PLL, WAIT_LOCK, FILTER, RELEASE, RUN and FAULT.
REQ-017 In RST_PLL: `pll_rst`=1 and all `domain_reset_n`=0; the state SHALL last exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
REQ-018 In WAIT_LOCK: `pll_rst`=0; lock high SHALL go to FILTER; if the timeout counter reaches LOCK_TIMEOUT_CYCLES-1 without lock, the attempt has failed.
REQ-019 The timeout counter SHALL start at 0 on entry to WAIT_LOCK and SHALL keep counting through FILTER; it is not cleared when lock drops during FILTER.
REQ-020 In FILTER: LOCK_FILTER_CYCLES consecutive lock-high cycles SHALL go to RELEASE; lock low SHALL return to WAIT_LOCK and clear the filter counter.
REQ-021 If the timeout expires in FILTER, the attempt has failed.
REQ-022 On a failed attempt: if `retry_count` < MAX_RETRIES, SHALL increment `retry_count` and go to RST_PLL; otherwise SHALL go to FAULT.
REQ-023 In RELEASE: SHALL deassert `domain_reset_n[i]` on the (i+1)-th RELEASE cycle (index 0 first, one per cycle), then go to RUN after NUM_DOMAINS cycles.
REQ-024 In RUN: `ready`=1; `retry_count` SHALL be cleared to 0 on entry to RUN.
REQ-025 Lock low in RUN or RELEASE SHALL, in the same cycle, assert all `domain_reset_n`=0 and drop `ready`; next state is RST_PLL and `retry_count` increments (lock loss counts as a failed attempt; goes to FAULT if already at MAX_RETRIES).
REQ-026 In FAULT: `fault`=1, `pll_rst`=1, all domains held in reset; `restart_req` SHALL exit FAULT to RST_PLL with `retry_count` cleared.
REQ-027 `restart_req` in any other state SHALL force RST_PLL with all counters and `retry_count` cleared; `restart_req` takes priority over simultaneous lock-loss or timeout.
REQ-028 `ready` SHALL equal 1 only in RUN; `fault` SHALL equal 1 only in FAULT; all outputs are registered.
REQ-029 Counters SHALL be sized by clog2 of their limit and SHALL saturate rather than wrap.

Reset
REQ-030 While `reset_n`=0: state=RST_PLL, `pll_rst`=1, `domain_reset_n`=all 0, `ready`=0, `fault`=0, `retry_count`=0, all counters and synchronizer flops=0.
REQ-031 The first cycle after reset release SHALL count as RST_PLL cycle 1.
REQ-032 Reset asserted mid-sequence SHALL abort immediately with no partial domain release.

Structure
REQ-033 The shared package SHALL hold the state enum and the default parameter constants.
REQ-034 The synchronizer SHALL be a separate sub-module, sync_2ff, with 1-bit data.

Verification (bench parameters: RST_PULSE=4, FILTER=8, TIMEOUT=32, MAX_RETRIES=2, NUM_DOMAINS=5)
REQ-035 Clean bring-up: `pll_locked` rises 10 cycles after reset -> `pll_rst` high exactly 4 cycles; `domain_reset_n` goes 00001, 00011 … 11111 on consecutive cycles; `ready`=1 after 5 RELEASE cycles.
REQ-036 Glitchy lock: lock high 5 cycles, low 1, then steady -> no release until 8 consecutive synchronized-high cycles.
REQ-037 Never locks -> 3 attempts, each with a 4-cycle `pll_rst` pulse; `retry_count` steps 0, 1, 2; then FAULT with `fault`=1 and `pll_rst`=1.
REQ-038 Lock drops in RUN -> all `domain_reset_n`=0 and `ready`=0 within 2 sync cycles plus 1; `retry_count`=1; re-lock -> RUN with `retry_count`=0.
REQ-039 FAULT then `restart_req` pulse -> RST_PLL with `retry_count`=0; `restart_req` coincident with lock loss -> `retry_count`=0.
REQ-040 `reset_n` asserted during RELEASE at domain 2 -> next cycle all `domain_reset_n`=0 and `pll_rst`=1.
